// File: rtl/adc_sample_scheduler_if.sv
// rtl/adc_sample_scheduler_if.sv - sample delivery stream between scheduler and consumer
interface adc_sample_scheduler_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 10
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [DATA_W-1:0] sample_data;
    logic [CH_W-1:0]   sample_ch;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output sample_data,
        output sample_ch,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_ch,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/adc_sample_scheduler.sv
// rtl/adc_sample_scheduler.sv - periodic SPI ADC conversion scheduler with channel rotation (optional ADC_SCHED_TIMEOUT_EN)
module adc_sample_scheduler #(
    parameter int NUM_CH        = 2,
    parameter int DATA_W        = 10,
    parameter int SAMPLE_PERIOD = 64,
    parameter int TIMEOUT       = 32,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  sck,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [NUM_CH-1:0]     ch_mask,
    input  logic                  clear_err,
    input  logic                  reading,
    input  logic                  write_en,
    input  logic                  miso,
    output logic                  start_read,
    output logic [CH_W-1:0]       channel_sel,
    adc_sample_scheduler_if.master smp,
    output logic                  overrun,
    output logic                  timeout_err
);
    localparam int CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REQ, S_BUSY} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CH_W-1:0]   r_chan;
    logic              r_first;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_data;
    logic [CH_W-1:0]   r_ch;
    logic              r_valid;
    logic              r_overrun;
    logic              w_can_start;
    logic              w_capture;
    logic              w_timeout;
    logic [CH_W-1:0]   w_next_ch;
    int                w_base;

    // First enabled channel at or after 'start', wrapping around the mask.
    function automatic logic [CH_W-1:0] next_channel(input logic [NUM_CH-1:0] mask, input int start);
        logic [CH_W-1:0] sel;
        logic            found;
        int              idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (start + k) % NUM_CH;
            if (!found && mask[idx]) begin
                sel   = CH_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign w_can_start = enable && (ch_mask != '0);
    assign w_capture   = (r_state == S_BUSY) && write_en;
    assign w_base      = r_first ? 0 : int'(r_chan) + 1;
    assign w_next_ch   = next_channel(ch_mask, w_base);

    always_ff @(posedge sck) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_can_start) w_next = S_REQ;
            S_REQ:  w_next = S_BUSY;
            S_BUSY: if (write_en || w_timeout) w_next = S_WAIT;
            S_WAIT: if (r_wait_cnt == '0) w_next = w_can_start ? S_REQ : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        start_read = (r_state == S_REQ);
    end

    always_ff @(posedge sck) begin
        if (reset) begin
            r_chan     <= '0;
            r_first    <= 1'b1;
            r_wait_cnt <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_ch       <= '0;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_next == S_REQ && r_state != S_REQ) begin
                r_chan  <= w_next_ch;
                r_first <= 1'b0;
            end

            if (w_next == S_WAIT && r_state != S_WAIT) begin
                r_wait_cnt <= CNT_W'(SAMPLE_PERIOD - 1);
            end else if (r_state == S_WAIT && r_wait_cnt != '0) begin
                r_wait_cnt <= r_wait_cnt - CNT_W'(1);
            end

            if (r_state == S_BUSY && reading) begin
                r_shift <= {r_shift[DATA_W-2:0], miso};
            end

            // A consumer accepting in the capture cycle frees the slot for the new sample.
            if (w_capture && (!r_valid || smp.sample_ready)) begin
                r_data  <= r_shift;
                r_ch    <= r_chan;
                r_valid <= 1'b1;
            end else if (r_valid && smp.sample_ready) begin
                r_valid <= 1'b0;
            end

            if (w_capture && r_valid && !smp.sample_ready) begin
                r_overrun <= 1'b1;
            end else if (clear_err) begin
                r_overrun <= 1'b0;
            end
        end
    end

`ifdef ADC_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_got_bit;
    logic            r_timeout_err;

    // Counter holds the number of cycles elapsed since REQ.
    assign w_timeout = (r_state == S_BUSY) && !r_got_bit && !reading && !write_en
                       && (r_to_cnt >= TO_W'(TIMEOUT - 1));

    always_ff @(posedge sck) begin
        if (reset) begin
            r_to_cnt      <= '0;
            r_got_bit     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == S_REQ) begin
                r_to_cnt  <= TO_W'(1);
                r_got_bit <= 1'b0;
            end else if (r_state == S_BUSY) begin
                if (reading) r_got_bit <= 1'b1;
                if (r_to_cnt < TO_W'(TIMEOUT)) r_to_cnt <= r_to_cnt + TO_W'(1);
            end

            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end else if (clear_err) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign channel_sel      = r_chan;
    assign smp.sample_data  = r_data;
    assign smp.sample_ch    = r_ch;
    assign smp.sample_valid = r_valid;
    assign overrun          = r_overrun;
endmodule
